// File: rtl/spinner_quad_pkg.sv
// Shared types and helpers for the quadrature spinner emulator: AB phase
// encoding, phase stepping and width-parameterised saturating addition.
package spinner_quad_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_t;

    localparam quad_t ENC_RESET = Q11;

    function automatic quad_t quad_next(input quad_t q);
        case (q)
            Q00:     return Q01;
            Q01:     return Q11;
            Q11:     return Q10;
            default: return Q00;
        endcase
    endfunction

    function automatic quad_t quad_prev(input quad_t q);
        case (q)
            Q00:     return Q10;
            Q10:     return Q11;
            Q11:     return Q01;
            default: return Q00;
        endcase
    endfunction

    // Symmetric clamp to +/-(2^(w-1)-1) so the result never wraps in a w-bit register.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] sum;
        logic signed [32:0] lim;
        logic signed [32:0] nlim;
        sum  = 33'(a) + 33'(b);
        lim  = (33'sd1 <<< (w - 1)) - 33'sd1;
        nlim = -lim;
        if (sum > lim)  return lim[31:0];
        if (sum < nlim) return nlim[31:0];
        return sum[31:0];
    endfunction

endpackage

// File: rtl/spinner_quad_emu_if.sv
// Bus bundle between the input source (mouse/joystick) and the spinner emulator.
// With SPINNER_QUAD_INDEX_EN defined the bundle also carries per-channel index pulses.
interface spinner_quad_emu_if #(
    parameter int CHANNELS = 2,
    parameter int DELTA_W  = 9
);
    logic [CHANNELS-1:0]         delta_toggle;
    logic [CHANNELS*DELTA_W-1:0] delta;
    logic [CHANNELS-1:0]         joy_r;
    logic [CHANNELS-1:0]         joy_l;
    logic [CHANNELS-1:0]         invert;
    logic [2*CHANNELS-1:0]       enc;
    logic [CHANNELS-1:0]         busy;
`ifdef SPINNER_QUAD_INDEX_EN
    logic [CHANNELS-1:0]         index;
`endif

    modport master (
        output delta_toggle, delta, joy_r, joy_l, invert,
        input  enc, busy
`ifdef SPINNER_QUAD_INDEX_EN
        , input index
`endif
    );

    modport slave (
        input  delta_toggle, delta, joy_r, joy_l, invert,
        output enc, busy
`ifdef SPINNER_QUAD_INDEX_EN
        , output index
`endif
    );
endinterface

// File: rtl/spinner_quad_channel.sv
// One spinner channel: pending-step accumulator, delta/joystick loading and AB phase output.
// SPINNER_QUAD_INDEX_EN adds a per-revolution phase counter with a one-cycle index pulse.
module spinner_quad_channel
    import spinner_quad_pkg::*;
#(
    parameter int POS_W       = 12,
    parameter int DELTA_W     = 9,
    parameter int JOY_PERIOD  = 48000,
    parameter int JOY_STEP    = 7
`ifdef SPINNER_QUAD_INDEX_EN
    , parameter int INDEX_COUNT = 96
`endif
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      delta_toggle,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic                      joy_r,
    input  logic                      joy_l,
    input  logic                      invert,
    output logic [1:0]                enc,
    output logic                      busy
`ifdef SPINNER_QUAD_INDEX_EN
    , output logic                    index
`endif
);

    localparam int JOY_W = (JOY_PERIOD > 1) ? $clog2(JOY_PERIOD) : 1;
    localparam logic signed [POS_W-1:0] ONE     = POS_W'(1);
    localparam logic signed [POS_W-1:0] JOY_POS = POS_W'(JOY_STEP);

    quad_t                    enc_q, enc_next;
    logic signed [POS_W-1:0]  pending, pend_step, pend_next;
    logic signed [31:0]       sum_w;
    logic [JOY_W-1:0]         joy_cnt, joy_cnt_next;
    logic                     tog_prev, step_en, pend_pos, dir_pos;
    logic                     delta_evt, joy_one, joy_load;

    always_comb begin
        step_en      = tick && (pending != '0);
        pend_pos     = !pending[POS_W-1];
        dir_pos      = pend_pos ^ invert;
        enc_next     = enc_q;
        pend_step    = pending;
        sum_w        = '0;
        delta_evt    = delta_toggle ^ tog_prev;
        joy_one      = joy_r ^ joy_l;
        joy_load     = joy_one && (joy_cnt == JOY_W'(JOY_PERIOD - 1));
        joy_cnt_next = '0;

        if (step_en) begin
            enc_next  = dir_pos ? quad_next(enc_q) : quad_prev(enc_q);
            pend_step = pend_pos ? pending - ONE : pending + ONE;
        end

        // A delta against the current backlog direction replaces it instead of cancelling.
        pend_next = pend_step;
        if (delta_evt && (delta != '0)) begin
            if ((pend_step == '0) || (pend_step[POS_W-1] == delta[DELTA_W-1]))
                sum_w = sat_add(32'(pend_step), 32'(delta), POS_W);
            else
                sum_w = sat_add(32'sd0, 32'(delta), POS_W);
            pend_next = sum_w[POS_W-1:0];
        end

        if (joy_one && !joy_load)
            joy_cnt_next = joy_cnt + 1'b1;
        if (joy_load)
            pend_next = joy_r ? JOY_POS : -JOY_POS;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            enc_q    <= ENC_RESET;
            pending  <= '0;
            busy     <= 1'b0;
            joy_cnt  <= '0;
            tog_prev <= 1'b0;
        end else begin
            enc_q    <= enc_next;
            pending  <= pend_next;
            busy     <= (pending != '0);
            joy_cnt  <= joy_cnt_next;
            tog_prev <= delta_toggle;
        end
    end

    assign enc = enc_q;

`ifdef SPINNER_QUAD_INDEX_EN
    localparam int PH_W = (INDEX_COUNT > 1) ? $clog2(INDEX_COUNT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(INDEX_COUNT - 1);

    logic [PH_W-1:0] phase, phase_next;
    logic            wrap;

    // Phase follows the emitted direction, so invert also reverses the count.
    always_comb begin
        phase_next = phase;
        wrap       = 1'b0;
        if (step_en) begin
            if (dir_pos) begin
                if (phase == PH_LAST) begin
                    phase_next = '0;
                    wrap       = 1'b1;
                end else begin
                    phase_next = phase + 1'b1;
                end
            end else begin
                if (phase == '0) begin
                    phase_next = PH_LAST;
                    wrap       = 1'b1;
                end else begin
                    phase_next = phase - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            phase <= '0;
            index <= 1'b0;
        end else begin
            phase <= phase_next;
            index <= wrap;
        end
    end
`endif

endmodule

// File: rtl/spinner_quad_emu.sv
// Multi-channel mouse/joystick to quadrature spinner emulator: shared step divider plus
// CHANNELS independent channels. SPINNER_QUAD_INDEX_EN enables per-channel index pulses.
module spinner_quad_emu #(
    parameter int CHANNELS   = 2,
    parameter int POS_W      = 12,
    parameter int DELTA_W    = 9,
    parameter int STEP_DIV   = 600,
    parameter int JOY_PERIOD = 48000,
    parameter int JOY_STEP   = 7
`ifdef SPINNER_QUAD_INDEX_EN
    , parameter int INDEX_COUNT = 96
`endif
) (
    input  logic               clk_sys,
    input  logic               reset,
    spinner_quad_emu_if.slave  bus
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(STEP_DIV - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        spinner_quad_channel #(
            .POS_W      (POS_W),
            .DELTA_W    (DELTA_W),
            .JOY_PERIOD (JOY_PERIOD),
            .JOY_STEP   (JOY_STEP)
`ifdef SPINNER_QUAD_INDEX_EN
            , .INDEX_COUNT (INDEX_COUNT)
`endif
        ) u_ch (
            .clk_sys      (clk_sys),
            .reset        (reset),
            .tick         (tick),
            .delta_toggle (bus.delta_toggle[i]),
            .delta        (bus.delta[i*DELTA_W +: DELTA_W]),
            .joy_r        (bus.joy_r[i]),
            .joy_l        (bus.joy_l[i]),
            .invert       (bus.invert[i]),
            .enc          (bus.enc[2*i +: 2]),
            .busy         (bus.busy[i])
`ifdef SPINNER_QUAD_INDEX_EN
            , .index      (bus.index[i])
`endif
        );
    end

endmodule

// File: tb/tb_spinner_quad_emu.sv
// Bench for spinner_quad_emu against an integer reference model of the spinner rules.
// The index scenario is built only when SPINNER_QUAD_INDEX_EN is defined.
`timescale 1ns/1ps
module tb_spinner_quad_emu;

    localparam int CH   = 2;
    localparam int POS_W = 6;
    localparam int DW   = 9;
    localparam int SD   = 4;
    localparam int JP   = 10;
    localparam int JS   = 7;
    localparam int IC   = 4;
    localparam int PMAX = (1 << (POS_W - 1)) - 1;
    localparam logic [1:0] GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    spinner_quad_emu_if #(.CHANNELS(CH), .DELTA_W(DW)) bus ();

    spinner_quad_emu #(
        .CHANNELS(CH), .POS_W(POS_W), .DELTA_W(DW), .STEP_DIV(SD),
        .JOY_PERIOD(JP), .JOY_STEP(JS)
`ifdef SPINNER_QUAD_INDEX_EN
        , .INDEX_COUNT(IC)
`endif
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: pending steps as an int, encoder as a position in the Gray cycle.
    int m_div;
    int m_pend [CH];
    int m_pos  [CH];
    int m_jc   [CH];
    bit m_prev [CH];
    bit m_busy [CH];
    int m_ph   [CH];
    bit m_idx  [CH];

    function automatic int clamp(input int v);
        if (v > PMAX)  return PMAX;
        if (v < -PMAX) return -PMAX;
        return v;
    endfunction

    task automatic model_update();
        bit tk;
        bit pos;
        int p;
        int d;
        logic signed [DW-1:0] ds;
        if (reset) begin
            m_div = 0;
            for (int c = 0; c < CH; c++) begin
                m_pend[c] = 0; m_pos[c] = 2; m_jc[c] = 0; m_prev[c] = 0;
                m_busy[c] = 0; m_ph[c] = 0; m_idx[c] = 0;
            end
        end else begin
            tk = (m_div == SD - 1);
            m_div = tk ? 0 : m_div + 1;
            for (int c = 0; c < CH; c++) begin
                p = m_pend[c];
                m_busy[c] = (p != 0);
                m_idx[c] = 0;
                if (tk && p != 0) begin
                    pos = (p > 0) ^ bus.invert[c];
                    m_pos[c] = (m_pos[c] + (pos ? 1 : 3)) % 4;
                    if (pos) begin
                        m_ph[c] = m_ph[c] + 1;
                        if (m_ph[c] == IC) begin m_ph[c] = 0; m_idx[c] = 1; end
                    end else begin
                        if (m_ph[c] == 0) begin m_ph[c] = IC; m_idx[c] = 1; end
                        m_ph[c] = m_ph[c] - 1;
                    end
                    p = (p > 0) ? p - 1 : p + 1;
                end
                if (bus.delta_toggle[c] != m_prev[c]) begin
                    ds = bus.delta[c*DW +: DW];
                    d = ds;
                    if (d != 0) begin
                        if (p == 0 || ((p > 0) == (d > 0))) p = clamp(p + d);
                        else p = clamp(d);
                    end
                end
                m_prev[c] = bus.delta_toggle[c];
                if (bus.joy_r[c] != bus.joy_l[c]) begin
                    if (m_jc[c] == JP - 1) begin
                        m_jc[c] = 0;
                        p = bus.joy_r[c] ? JS : -JS;
                    end else begin
                        m_jc[c] = m_jc[c] + 1;
                    end
                end else begin
                    m_jc[c] = 0;
                end
                m_pend[c] = p;
            end
        end
    endtask

    always @(posedge clk_sys or posedge reset) model_update();

    task automatic apply_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        bus.delta_toggle = '0; bus.delta = '0; bus.joy_r = '0; bus.joy_l = '0; bus.invert = '0;
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic pulse_delta(input int c, input int d);
        logic signed [DW-1:0] dv;
        dv = DW'(d);
        bus.delta[c*DW +: DW] = dv;
        bus.delta_toggle[c] = ~bus.delta_toggle[c];
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.enc !== 4'b1111) begin
            failures++; $display("FAIL reset_enc got=%b want=1111", bus.enc);
        end
        checks++;
        if (bus.busy !== 2'b00) begin
            failures++; $display("FAIL reset_busy got=%b want=00", bus.busy);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk_sys);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (bus.enc[2*c +: 2] !== GRAY[m_pos[c]] || bus.busy[c] !== m_busy[c]) begin
                    failures++;
                    $display("FAIL reset_idle ch%0d got enc=%b busy=%b want enc=%b busy=%b",
                             c, bus.enc[2*c +: 2], bus.busy[c], GRAY[m_pos[c]], m_busy[c]);
                end
            end
        end
    endtask

    task automatic test_delta_sequence();
        logic [1:0] last;
        logic [1:0] seen [$];
        logic [1:0] want [3] = '{2'b10, 2'b00, 2'b01};
        int first_k;
        apply_reset();
        pulse_delta(0, 3);
        last = bus.enc[1:0];
        first_k = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_sys);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (bus.enc[2*c +: 2] !== GRAY[m_pos[c]] || bus.busy[c] !== m_busy[c]) begin
                    failures++;
                    $display("FAIL delta_seq ch%0d t=%0t got enc=%b busy=%b want enc=%b busy=%b",
                             c, $time, bus.enc[2*c +: 2], bus.busy[c], GRAY[m_pos[c]], m_busy[c]);
                end
            end
            if (bus.enc[1:0] !== last) begin
                if (first_k < 0) first_k = k;
                seen.push_back(bus.enc[1:0]);
                last = bus.enc[1:0];
            end
        end
        checks++;
        if (seen.size() != 3) begin
            failures++; $display("FAIL delta_seq_count got=%0d want=3", seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    failures++; $display("FAIL delta_seq_step%0d got=%b want=%b", i, seen[i], want[i]);
                end
            end
        end
        checks++;
        if (first_k < 1 || first_k > SD + 2) begin
            failures++; $display("FAIL delta_latency got=%0d want<=%0d", first_k, SD + 2);
        end
        checks++;
        if (bus.busy[0] !== 1'b0 || bus.enc[3:2] !== 2'b11) begin
            failures++; $display("FAIL delta_idle got busy0=%b enc1=%b want 0 11", bus.busy[0], bus.enc[3:2]);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] last;
        logic [1:0] seen [$];
        apply_reset();
        pulse_delta(0, 5);
        @(negedge clk_sys);
        pulse_delta(0, -2);
        last = bus.enc[1:0];
        repeat (30) begin
            @(negedge clk_sys);
            checks++;
            if (bus.enc[1:0] !== GRAY[m_pos[0]] || bus.busy[0] !== m_busy[0]) begin
                failures++;
                $display("FAIL reverse t=%0t got enc=%b busy=%b want enc=%b busy=%b",
                         $time, bus.enc[1:0], bus.busy[0], GRAY[m_pos[0]], m_busy[0]);
            end
            if (bus.enc[1:0] !== last) begin
                seen.push_back(bus.enc[1:0]);
                last = bus.enc[1:0];
            end
        end
        checks++;
        if (seen.size() != 2) begin
            failures++; $display("FAIL reverse_count got=%0d want=2", seen.size());
        end else begin
            checks++;
            if (seen[0] !== 2'b01 || seen[1] !== 2'b00) begin
                failures++; $display("FAIL reverse_seq got=%b,%b want=01,00", seen[0], seen[1]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] last;
        int steps;
        int guard;
        apply_reset();
        guard = 0;
        while (m_div != SD - 1 && guard < 10) begin
            @(negedge clk_sys);
            guard++;
        end
        checks++;
        if (m_div != SD - 1) begin
            failures++; $display("FAIL sat_sync got div=%0d want=%0d", m_div, SD - 1);
        end
        last = bus.enc[1:0];
        steps = 0;
        for (int i = 0; i < 4; i++) begin
            pulse_delta(0, 20);
            @(negedge clk_sys);
            if (bus.enc[1:0] !== last) begin steps++; last = bus.enc[1:0]; end
        end
        repeat (PMAX * SD + 20) begin
            @(negedge clk_sys);
            checks++;
            if (bus.enc[1:0] !== GRAY[m_pos[0]] || bus.busy[0] !== m_busy[0]) begin
                failures++;
                $display("FAIL saturation t=%0t got enc=%b busy=%b want enc=%b busy=%b",
                         $time, bus.enc[1:0], bus.busy[0], GRAY[m_pos[0]], m_busy[0]);
            end
            if (bus.enc[1:0] !== last) begin steps++; last = bus.enc[1:0]; end
        end
        checks++;
        if (steps != PMAX) begin
            failures++; $display("FAIL sat_steps got=%0d want=%0d", steps, PMAX);
        end
    endtask

    task automatic test_joystick();
        int busy_k;
        logic [1:0] hold;
        apply_reset();
        bus.joy_r[0] = 1'b1;
        busy_k = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk_sys);
            checks++;
            if (bus.enc[1:0] !== GRAY[m_pos[0]] || bus.busy[0] !== m_busy[0]) begin
                failures++;
                $display("FAIL joy_r t=%0t got enc=%b busy=%b want enc=%b busy=%b",
                         $time, bus.enc[1:0], bus.busy[0], GRAY[m_pos[0]], m_busy[0]);
            end
            if (busy_k < 0 && bus.busy[0] === 1'b1) busy_k = k;
        end
        checks++;
        if (busy_k != JP + 1) begin
            failures++; $display("FAIL joy_first_load got=%0d want=%0d", busy_k, JP + 1);
        end
        bus.joy_r[0] = 1'b0;
        repeat (60) begin
            @(negedge clk_sys);
            checks++;
            if (bus.enc[1:0] !== GRAY[m_pos[0]] || bus.busy[0] !== m_busy[0]) begin
                failures++;
                $display("FAIL joy_drain t=%0t got enc=%b busy=%b want enc=%b busy=%b",
                         $time, bus.enc[1:0], bus.busy[0], GRAY[m_pos[0]], m_busy[0]);
            end
        end
        hold = bus.enc[1:0];
        bus.joy_r[0] = 1'b1;
        bus.joy_l[0] = 1'b1;
        repeat (3 * JP) begin
            @(negedge clk_sys);
            checks++;
            if (bus.busy[0] !== 1'b0 || bus.enc[1:0] !== hold) begin
                failures++;
                $display("FAIL joy_both got busy=%b enc=%b want busy=0 enc=%b", bus.busy[0], bus.enc[1:0], hold);
            end
        end
        bus.joy_r[0] = 1'b0;
        bus.joy_l[0] = 1'b0;
    endtask

    task automatic test_invert_reset();
        logic [1:0] last;
        logic [1:0] seen [$];
        apply_reset();
        bus.invert[0] = 1'b1;
        pulse_delta(0, 2);
        last = bus.enc[1:0];
        repeat (20) begin
            @(negedge clk_sys);
            checks++;
            if (bus.enc[1:0] !== GRAY[m_pos[0]]) begin
                failures++; $display("FAIL invert t=%0t got=%b want=%b", $time, bus.enc[1:0], GRAY[m_pos[0]]);
            end
            if (bus.enc[1:0] !== last) begin seen.push_back(bus.enc[1:0]); last = bus.enc[1:0]; end
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== 2'b01 || seen[1] !== 2'b00) begin
            failures++; $display("FAIL invert_seq got count=%0d want 2 steps 01,00", seen.size());
        end
        pulse_delta(0, 20);
        repeat (10) @(negedge clk_sys);
        checks++;
        if (bus.busy[0] !== 1'b1) begin
            failures++; $display("FAIL midrun_busy got=%b want=1", bus.busy[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.enc !== 4'b1111 || bus.busy !== 2'b00) begin
            failures++; $display("FAIL async_reset got enc=%b busy=%b want 1111 00", bus.enc, bus.busy);
        end
        @(negedge clk_sys);
        bus.invert = '0;
        bus.delta_toggle = '0;
        reset = 1'b0;
    endtask

    task automatic test_random();
        int d;
        apply_reset();
        bus.invert = 2'($urandom_range(0, 3));
        repeat (400) begin
            @(negedge clk_sys);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (bus.enc[2*c +: 2] !== GRAY[m_pos[c]] || bus.busy[c] !== m_busy[c]) begin
                    failures++;
                    $display("FAIL random ch%0d t=%0t got enc=%b busy=%b want enc=%b busy=%b",
                             c, $time, bus.enc[2*c +: 2], bus.busy[c], GRAY[m_pos[c]], m_busy[c]);
                end
                if ($urandom_range(0, 5) == 0) begin
                    d = int'($urandom_range(0, 80)) - 40;
                    pulse_delta(c, d);
                end
                if ($urandom_range(0, 29) == 0) begin
                    bus.joy_r[c] = 1'($urandom_range(0, 1));
                    bus.joy_l[c] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 49) == 0) bus.invert[c] = ~bus.invert[c];
            end
        end
        bus.joy_r = '0;
        bus.joy_l = '0;
    endtask

`ifdef SPINNER_QUAD_INDEX_EN
    task automatic test_index();
        int pulses;
        logic prev;
        apply_reset();
        pulse_delta(0, 9);
        pulses = 0;
        prev = 1'b0;
        for (int phase_run = 0; phase_run < 2; phase_run++) begin
            repeat (60) begin
                @(negedge clk_sys);
                checks++;
                if (bus.index[0] !== m_idx[0] || bus.enc[1:0] !== GRAY[m_pos[0]]) begin
                    failures++;
                    $display("FAIL index t=%0t got idx=%b enc=%b want idx=%b enc=%b",
                             $time, bus.index[0], bus.enc[1:0], m_idx[0], GRAY[m_pos[0]]);
                end
                checks++;
                if (prev === 1'b1 && bus.index[0] === 1'b1) begin
                    failures++; $display("FAIL index_width t=%0t got two-cycle pulse want one", $time);
                end
                if (bus.index[0] === 1'b1) pulses++;
                prev = bus.index[0];
            end
            checks++;
            if (pulses != ((phase_run == 0) ? 2 : 3)) begin
                failures++; $display("FAIL index_count run%0d got=%0d want=%0d", phase_run, pulses,
                                     (phase_run == 0) ? 2 : 3);
            end
            if (phase_run == 0) pulse_delta(0, -2);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.delta_toggle = '0;
        bus.delta        = '0;
        bus.joy_r        = '0;
        bus.joy_l        = '0;
        bus.invert       = '0;
        test_reset();
        test_delta_sequence();
        test_reverse();
        test_saturation();
        test_joystick();
        test_invert_reset();
        test_random();
`ifdef SPINNER_QUAD_INDEX_EN
        test_index();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
